irda_sip_sched: RTL
===================

Name: irda_sip_sched

Overview:
- Upstream scheduler for irda_sip_gen. While fast mode (MIR/FIR) is enabled, it raises a SIP request on `sip_o` immediately on enable, then again every SIP_PERIOD_MS.
- Requests are deferred while the transmitter is busy, and it flags when the IrDA 500 ms SIP limit is exceeded.
- It holds the request level until irda_sip_gen returns `sip_end_i`. It then guarantees at least one low cycle so the generator's rise detector re-arms.

Parameters:
- CLK_PER_MS, 40000, clk cycles per millisecond (prescaler terminal count).
- SIP_PERIOD_MS, 450, nominal interval between SIP requests, in ms.
- MAX_MS, 500, interval after which an undelivered SIP is overdue, in ms (MAX_MS >= SIP_PERIOD_MS).
- REQ_TIMEOUT, 1023, max clk cycles to wait for `sip_end_i` before abandoning a request.

Ports:
- clk  in  1  system clock
- wb_rst_i  in  1  reset; synchronous, active-high
- fast_enable  in  1  fast (MIR/FIR) mode active
- tx_busy  in  1  transmitter is sending a frame; a SIP must not start while high
- sip_force  in  1  one-cycle software request for an immediate SIP
- sip_end_i  in  1  end-of-SIP from irda_sip_gen
- sip_o  out  1  SIP request level to irda_sip_gen
- sip_pending  out  1  a SIP is due but not yet completed
- sip_overdue  out  1  MAX_MS elapsed without a completed SIP
- sip_err  out  1  one-cycle pulse: request abandoned on REQ_TIMEOUT

Behaviour:
- Reset (wb_rst_i=1 at a clk edge):
  - state = ST_OFF.
  - All outputs 0: sip_o, sip_pending, sip_overdue, sip_err.
  - Counters cleared: prescaler, ms_cnt, timeout counter.
- Counters:
  - Prescaler counts 0..CLK_PER_MS-1 and wraps.
  - ms_cnt (10 bits) increments on prescaler wrap and saturates at 1023.
  - Timeout counter is 10 bits.
- ST_OFF:
  - Outputs and counters held at 0.
  - fast_enable=1 -> ST_DUE (first SIP issued on entering fast mode).
- ST_COUNT:
  - Prescaler and ms_cnt run.
  - ms_cnt == SIP_PERIOD_MS, or sip_force=1 -> ST_DUE.
- ST_DUE:
  - sip_pending=1; prescaler and ms_cnt keep running.
  - tx_busy=0 -> ST_REQ; sip_o=1 from the next cycle.
  - tx_busy=1 -> stay (defer).
- ST_REQ:
  - sip_o=1 and sip_pending=1.
  - Timeout counter increments every cycle.
  - sip_end_i=1 -> ST_GAP.
  - Timeout counter == REQ_TIMEOUT -> ST_GAP with a sip_err pulse in that cycle.
- ST_GAP (exactly 1 cycle):
  - sip_o=0, sip_pending=0, sip_overdue=0 (cleared on completion or abandon).
  - Prescaler, ms_cnt and timeout counter cleared.
  - -> ST_COUNT.
- Timing:
  - From entry to ST_COUNT, sip_o rises SIP_PERIOD_MS*CLK_PER_MS+1 cycles later (one cycle in ST_DUE) when tx_busy=0.
  - From sip_force in ST_COUNT, sip_o rises 2 cycles later.
- sip_overdue:
  - Set when ms_cnt reaches MAX_MS in ST_COUNT, ST_DUE or ST_REQ.
  - Sticky until ST_GAP.
- fast_enable=0 in any state -> ST_OFF next cycle.
  - sip_o drops immediately (abort mid-request).
  - No sip_err is raised.
- Simultaneous events:
  - sip_force during ST_DUE, ST_REQ or ST_GAP is ignored (already pending or just served).
  - sip_end_i outside ST_REQ is ignored.
  - sip_end_i and timeout in the same cycle: sip_end_i wins, no sip_err.
  - tx_busy only gates the ST_DUE -> ST_REQ transition. An in-flight request is not withdrawn when tx_busy rises.
- Widths:
  - Prescaler width is $clog2(CLK_PER_MS).
  - Comparisons are unsigned.
- All outputs are registered.

Decomposition:
- Shared package irda_sip_pkg holds:
  - State encoding: ST_OFF=0, ST_COUNT=1, ST_DUE=2, ST_REQ=3, ST_GAP=4; 3-bit state.
  - Default timing constants (CLK_PER_MS, SIP_PERIOD_MS, MAX_MS, REQ_TIMEOUT), also usable by irda_sip_gen benches.
- One sub-module, irda_ms_tick:
  - Prescaler plus ms_cnt with synchronous clear, run enable and a saturating count output.
  - The FSM stays in the top module.

Test Plan:
All scenarios use CLK_PER_MS=4, SIP_PERIOD_MS=3, MAX_MS=5, REQ_TIMEOUT=20.
1. Reset with fast_enable=0 -> all outputs 0. Raise fast_enable at cycle 0 -> sip_o=1 at cycle 2. Return sip_end_i at cycle 10 -> sip_o=0 at cycle 11, stays low for at least 1 cycle.
2. Periodic operation with a generator model answering 5 cycles after sip_o rises -> successive sip_o rising edges spaced 12+1+5+1 = 19 cycles apart; sip_err never asserts.
3. tx_busy held high across the due point for 30 cycles -> sip_pending=1, sip_o=0 throughout; sip_overdue=1 once ms_cnt=5. After tx_busy falls, sip_o rises the next cycle. On sip_end_i, sip_overdue clears.
4. No sip_end_i ever returned -> sip_o high for 20 cycles, then sip_err pulses exactly one cycle and sip_o=0. Next request follows 13 cycles later.
5. sip_force pulse 2 ms into ST_COUNT -> sip_o rises 2 cycles later. A second sip_force during ST_REQ -> no extra request.
6. fast_enable dropped mid-request, and wb_rst_i asserted mid-ST_DUE -> sip_o=0 next cycle, state ST_OFF, counters 0, no sip_err. Re-enable -> immediate SIP, as in scenario 1.

Source files
------------

// File: rtl/irda_sip_sched_pkg.sv
// irda_sip_pkg: shared state encoding and default timing for the SIP scheduler and generator benches
package irda_sip_pkg;
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_COUNT = 3'd1,
    ST_DUE   = 3'd2,
    ST_REQ   = 3'd3,
    ST_GAP   = 3'd4
  } sip_state_e;
  localparam int DEF_CLK_PER_MS    = 40000;
  localparam int DEF_SIP_PERIOD_MS = 450;
  localparam int DEF_MAX_MS        = 500;
  localparam int DEF_REQ_TIMEOUT   = 1023;
  function automatic logic sip_active(sip_state_e s);
    return s inside {ST_COUNT, ST_DUE, ST_REQ};
  endfunction
endpackage

// File: rtl/irda_sip_sched_if.sv
// irda_sip_sched_if: control inputs and SIP status outputs of the scheduler
interface irda_sip_sched_if;
  logic fast_enable;
  logic tx_busy;
  logic sip_force;
  logic sip_end_i;
  logic sip_o;
  logic sip_pending;
  logic sip_overdue;
  logic sip_err;
  modport master (output fast_enable, tx_busy, sip_force, sip_end_i,
                  input  sip_o, sip_pending, sip_overdue, sip_err);
  modport slave  (input  fast_enable, tx_busy, sip_force, sip_end_i,
                  output sip_o, sip_pending, sip_overdue, sip_err);
endinterface

// File: rtl/irda_sip_sched_ms_tick.sv
// irda_ms_tick: millisecond prescaler plus saturating 10-bit ms counter
module irda_ms_tick #(
  parameter int CLK_PER_MS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       run,
  output logic [9:0] ms_nxt
);
  localparam int PW = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    ms_cnt_q, ms_cnt_d;
  logic          wrap;
  // ms_nxt ignores clr so the scheduler can use it to pick its next state
  assign wrap   = run && presc_q == PW'(CLK_PER_MS - 1);
  assign ms_nxt = (wrap && ms_cnt_q != 10'h3ff) ? ms_cnt_q + 10'd1 : ms_cnt_q;
  always_comb begin
    presc_d  = clr ? '0 : !run ? presc_q : wrap ? '0 : presc_q + 1'b1;
    ms_cnt_d = clr ? '0 : ms_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      ms_cnt_q <= '0;
    end else begin
      presc_q  <= presc_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end
endmodule

// File: rtl/irda_sip_sched.sv
// irda_sip_sched: periodic SIP request scheduler feeding irda_sip_gen in MIR/FIR mode
module irda_sip_sched import irda_sip_pkg::*; #(
  parameter int CLK_PER_MS    = DEF_CLK_PER_MS,
  parameter int SIP_PERIOD_MS = DEF_SIP_PERIOD_MS,
  parameter int MAX_MS        = DEF_MAX_MS,
  parameter int REQ_TIMEOUT   = DEF_REQ_TIMEOUT
) (
  input logic              clk,
  input logic              wb_rst_i,
  irda_sip_sched_if.slave  bus
);
  sip_state_e state_q, state_d;
  logic [9:0] to_q, to_d, ms_nxt;
  logic       to_hit, clr, run;
  logic       sip_o_q, sip_o_d, sip_pending_q, sip_pending_d;
  logic       sip_overdue_q, sip_overdue_d, sip_err_q, sip_err_d;
  assign run = sip_active(state_q);
  assign clr = state_d inside {ST_OFF, ST_GAP};
  irda_ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk    (clk),
    .rst    (wb_rst_i),
    .clr    (clr),
    .run    (run),
    .ms_nxt (ms_nxt)
  );
  // decisions use next-cycle counter values so every output stays a pure register
  always_comb begin
    state_d = state_q;
    to_d    = state_q == ST_REQ ? to_q + 10'd1 : '0;
    to_hit  = to_d == 10'(REQ_TIMEOUT);
    case (state_q)
      ST_OFF:   state_d = ST_DUE;
      ST_COUNT: if (ms_nxt == 10'(SIP_PERIOD_MS) || bus.sip_force) state_d = ST_DUE;
      ST_DUE:   if (!bus.tx_busy) state_d = ST_REQ;
      ST_REQ:   if (bus.sip_end_i || to_hit) state_d = ST_GAP;
      ST_GAP:   state_d = ST_COUNT;
      default:  state_d = ST_OFF;
    endcase
    if (!bus.fast_enable) state_d = ST_OFF;
    sip_o_d       = state_d == ST_REQ;
    sip_pending_d = state_d inside {ST_DUE, ST_REQ};
    sip_err_d     = state_q == ST_REQ && state_d == ST_GAP && !bus.sip_end_i;
    sip_overdue_d = sip_active(state_d) && (sip_overdue_q || ms_nxt >= 10'(MAX_MS));
  end
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q       <= ST_OFF;
      to_q          <= '0;
      sip_o_q       <= 1'b0;
      sip_pending_q <= 1'b0;
      sip_overdue_q <= 1'b0;
      sip_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_q          <= to_d;
      sip_o_q       <= sip_o_d;
      sip_pending_q <= sip_pending_d;
      sip_overdue_q <= sip_overdue_d;
      sip_err_q     <= sip_err_d;
    end
  end
  assign bus.sip_o       = sip_o_q;
  assign bus.sip_pending = sip_pending_q;
  assign bus.sip_overdue = sip_overdue_q;
  assign bus.sip_err     = sip_err_q;
endmodule
